// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-byte blocks.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MATCH,
    PULSE,
    HOLDOFF
  } state_e;

  localparam logic [7:0] DEF_RST_CMD = 8'hFF;

  // Acknowledge byte echoed back to the host: bitwise complement of the command.
  function automatic logic [31:0] ack_byte(input logic [31:0] cmd);
    return ~cmd;
  endfunction

endpackage

// File: rtl/uart_cmd_reset_if.sv
// Receiver-side and request-side signal bundle for uart_cmd_reset.
// Optional ack transmit signals exist only when UART_CMD_RESET_ACK_EN is defined.
interface uart_cmd_reset_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 2
);
  logic              rx_data_fresh;
  logic [DATA_W-1:0] rx_data;
  logic              rst_req;
  logic              busy;
  logic [CNT_W-1:0]  match_cnt;
`ifdef UART_CMD_RESET_ACK_EN
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport master (output rx_data_fresh, rx_data, tx_busy,
                  input  rst_req, busy, match_cnt, tx_data, tx_start);
  modport slave  (input  rx_data_fresh, rx_data, tx_busy,
                  output rst_req, busy, match_cnt, tx_data, tx_start);
`else
  modport master (output rx_data_fresh, rx_data,
                  input  rst_req, busy, match_cnt);
  modport slave  (input  rx_data_fresh, rx_data,
                  output rst_req, busy, match_cnt);
`endif
endinterface

// File: rtl/uart_cmd_reset_rise_detect.sv
// Registered 1-bit rising-edge detector; an edge seen while rst is high is dropped.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q & ~rst;
endmodule

// File: rtl/uart_cmd_reset.sv
// Counts consecutive command bytes from the UART receiver and issues a reset-request pulse.
// Defining UART_CMD_RESET_ACK_EN adds a one-shot acknowledge byte toward the transmitter.
module uart_cmd_reset
  import uart_cmd_pkg::*;
#(
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] RST_CMD        = DATA_W'(DEF_RST_CMD),
  parameter int                RST_COUNT      = 3,
  parameter int                PULSE_CYCLES   = 4,
  parameter int                TIMEOUT_CYCLES = 1000,
  parameter int                HOLDOFF_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  uart_cmd_reset_if.slave bus
);
  localparam int CW   = $clog2(RST_COUNT + 1);
  localparam int TMAX = (TIMEOUT_CYCLES > PULSE_CYCLES)
                      ? ((TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES)
                      : ((PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES);
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_PULSE   = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_HOLD    = TW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            rst_req_q, busy_q;
  logic            accept, is_cmd, expire;

  rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.rx_data_fresh),
    .rise_o (accept)
  );

  assign is_cmd = (bus.rx_data == RST_CMD);
  // Expire one step before the timer would reach zero so the TIMEOUT_CYCLES-th gap is still valid.
  assign expire = (TIMEOUT_CYCLES != 0) && (tmr_q == TW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (accept && is_cmd) begin
          if (RST_COUNT == 1) begin
            state_d = PULSE;
            cnt_d   = '0;
            tmr_d   = T_PULSE;
          end else begin
            state_d = MATCH;
            cnt_d   = CW'(1);
            tmr_d   = T_TIMEOUT;
          end
        end
      end
      MATCH: begin
        if (accept) begin
          if (!is_cmd) begin
            state_d = IDLE;
            cnt_d   = '0;
            tmr_d   = '0;
          end else if (cnt_q == CW'(RST_COUNT - 1)) begin
            state_d = PULSE;
            cnt_d   = '0;
            tmr_d   = T_PULSE;
          end else begin
            cnt_d = cnt_q + CW'(1);
            tmr_d = T_TIMEOUT;
          end
        end else if (expire) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmr_d   = '0;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      PULSE: begin
        if (tmr_q == '0) begin
          state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
          tmr_d   = T_HOLD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      HOLDOFF: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      rst_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      rst_req_q <= (state_d == PULSE);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.rst_req   = rst_req_q;
  assign bus.busy      = busy_q;
  assign bus.match_cnt = cnt_q;

`ifdef UART_CMD_RESET_ACK_EN
  localparam logic [DATA_W-1:0] ACK_BYTE = DATA_W'(ack_byte(32'(RST_CMD)));

  logic              ack_pend_q, tx_start_q;
  logic [DATA_W-1:0] tx_data_q;

  // A new pulse entry re-arms the pending flag even if a stale ack is leaving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_pend_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      if (ack_pend_q && !bus.tx_busy) begin
        tx_start_q <= 1'b1;
        tx_data_q  <= ACK_BYTE;
        ack_pend_q <= 1'b0;
      end
      if (state_d == PULSE && state_q != PULSE) ack_pend_q <= 1'b1;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
`endif
endmodule

// File: tb/tb_uart_cmd_reset.sv
// Directed bench for uart_cmd_reset with a pulse scoreboard; ack checks when UART_CMD_RESET_ACK_EN is defined.
module tb_uart_cmd_reset;
  typedef struct {
    int start;
    int len;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;
  int   t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];

  uart_cmd_reset_if #(.DATA_W(8), .CNT_W(2)) bus ();

  uart_cmd_reset dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic prev_req = 1'b0;
  int   pstart = 0;
  always @(posedge clk) begin
    #1;
    if (bus.rst_req === 1'b1 && !prev_req) pstart = cyc;
    if (bus.rst_req !== 1'b1 && prev_req) obs_q.push_back('{start: pstart, len: cyc - pstart});
    prev_req = (bus.rst_req === 1'b1);
  end

`ifdef UART_CMD_RESET_ACK_EN
  int         ack_cnt = 0;
  logic [7:0] ack_data = 8'hxx;
  always @(posedge clk) begin
    #1;
    if (bus.tx_start === 1'b1) begin
      ack_cnt  = ack_cnt + 1;
      ack_data = bus.tx_data;
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, output int tacc);
    @(negedge clk);
    bus.rx_data       = d;
    bus.rx_data_fresh = 1'b1;
    @(posedge clk);
    #1;
    tacc = cyc;
    @(negedge clk);
    bus.rx_data_fresh = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_pulses(input string tag);
    pulse_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check({tag, "_missing_pulse_start"}, 32'hFFFF_FFFF, e.start);
      end else begin
        o = obs_q.pop_front();
        check({tag, "_pulse_start"}, o.start, e.start);
        check({tag, "_pulse_len"}, o.len, e.len);
      end
    end
    check({tag, "_extra_pulses"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    bus.rx_data_fresh = 1'b0;
    bus.rx_data       = 8'h00;
`ifdef UART_CMD_RESET_ACK_EN
    bus.tx_busy = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_req", bus.rst_req, 0);
    check("rst_hold_busy", bus.busy, 0);
    check("rst_hold_cnt", bus.match_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    #1;
    check("post_rst_req", bus.rst_req, 0);
    check("post_rst_cnt", bus.match_cnt, 0);

    // three commands 50 cycles apart
    send_byte(8'hFF, t);
    check("s1_cnt1", bus.match_cnt, 1);
    check("s1_busy1", bus.busy, 1);
    idle(49);
    send_byte(8'hFF, t);
    check("s1_cnt2", bus.match_cnt, 2);
    idle(49);
    send_byte(8'hFF, t);
    exp_q.push_back('{start: t, len: 4});
    check("s1_cnt_clr", bus.match_cnt, 0);
    check("s1_req_lat", bus.rst_req, 1);
    idle(19);
    #1;
    check("s1_busy_holdoff_end", bus.busy, 1);
    idle(1);
    #1;
    check("s1_busy_idle", bus.busy, 0);
    idle(5);
    check_pulses("s1");

    // mismatch breaks the sequence and does not start a new one
    send_byte(8'hFF, t);
    idle(4);
    send_byte(8'hFF, t);
    idle(4);
    send_byte(8'h00, t);
    check("s2_cnt_after_00", bus.match_cnt, 0);
    check("s2_busy_after_00", bus.busy, 0);
    idle(4);
    send_byte(8'hFF, t);
    check("s2_cnt_end", bus.match_cnt, 1);
    idle(30);
    check_pulses("s2");
    do_reset();

    // gap of 1001 cycles times out
    send_byte(8'hFF, t);
    idle(1000);
    send_byte(8'hFF, t);
    check("s3_cnt_restart", bus.match_cnt, 1);
    idle(4);
    send_byte(8'hFF, t);
    check("s3_cnt_two", bus.match_cnt, 2);
    idle(30);
    check_pulses("s3_timeout");
    do_reset();

    // gap of 999 cycles is still within the window
    send_byte(8'hFF, t);
    idle(998);
    send_byte(8'hFF, t);
    check("s3b_cnt2", bus.match_cnt, 2);
    idle(4);
    send_byte(8'hFF, t);
    exp_q.push_back('{start: t, len: 4});
    idle(30);
    check_pulses("s3_within");

    // five commands 2 cycles apart give a single pulse
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hFF, t);
      if (i == 2) exp_q.push_back('{start: t, len: 4});
      if (i < 4) idle(1);
    end
    check("s4_cnt_ignored", bus.match_cnt, 0);
    check("s4_busy", bus.busy, 1);
    idle(40);
    check_pulses("s4");

    // reset in the second pulse cycle
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hFF, t);
      if (i < 2) idle(2);
    end
    exp_q.push_back('{start: t, len: 2});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("s5_req_drop", bus.rst_req, 0);
    check("s5_busy_clr", bus.busy, 0);
    check("s5_cnt_clr", bus.match_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hFF, t);
      if (i < 2) idle(2);
    end
    exp_q.push_back('{start: t, len: 4});
    idle(30);
    check_pulses("s5");

    // fresh held high counts once
    @(negedge clk);
    bus.rx_data       = 8'hFF;
    bus.rx_data_fresh = 1'b1;
    idle(20);
    #1;
    check("s6_level_once", bus.match_cnt, 1);
    @(negedge clk);
    bus.rx_data_fresh = 1'b0;
    idle(5);
    check_pulses("s6");
    do_reset();

`ifdef UART_CMD_RESET_ACK_EN
    idle(2);
    ack_cnt = 0;
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hFF, t);
      if (i < 2) idle(2);
    end
    exp_q.push_back('{start: t, len: 4});
    idle(10);
    check("ack_held_off", ack_cnt, 0);
    @(negedge clk);
    bus.tx_busy = 1'b0;
    idle(30);
    check("ack_once", ack_cnt, 1);
    check("ack_data", ack_data, 8'h00);
    check_pulses("ack");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
